ysyx_23060240_axil_sram: RTL and testbench

// - AXI4-Lite responder (slave) backing the core's instruction/data memory; the far end of the
//   bus that the multi-cycle IFU and LSU drive as initiators. Replaces the combinational MEM path.
// - Holds a word-addressed RAM array. Answers each accepted read/write after a programmable

---
 rtl/ysyx_23060240_axi_pkg.sv | 29 ++
 rtl/ysyx_23060240_lfsr8.sv | 30 +++
 rtl/ysyx_23060240_axil_sram.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_23060240_axil_sram.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_axi_pkg.sv
// Shared AXI4-Lite response codes, SRAM responder state encoding and LFSR constants.
package ysyx_23060240_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4
  } sram_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 expressed as feedback taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060240_lfsr8.sv
// 8-bit Fibonacci LFSR used to jitter SRAM response latency (SRAM_RAND_DELAY_EN builds only).
module ysyx_23060240_lfsr8
  import ysyx_23060240_axi_pkg::*;
(
  input  logic       clk,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_en,
  output logic [7:0] o_q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  // Seed load has priority over stepping
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_q <= i_seed;
    end else if (i_en) begin
      r_q <= {r_q[6:0], w_fb};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ysyx_23060240_axil_sram.sv
// AXI4-Lite SRAM responder with programmable response latency.
// Optional SRAM_RAND_DELAY_EN adds an LFSR-driven 0..7 cycle jitter per request.
module ysyx_23060240_axil_sram
  import ysyx_23060240_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          LAT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  sram_state_e r_state;
  sram_state_e w_nstate;
  logic [4:0]  r_cnt;
  logic [4:0]  w_ncnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic        r_bvalid;
  logic [31:0] r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_wr_req;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_accept;
  logic                  w_rd_done;
  logic                  w_wr_done;
  logic [4:0]            w_delay;
  logic [31:0]           w_cur_addr;
  logic [31:0]           w_cur_wdata;
  logic [3:0]            w_cur_wstrb;
  logic [32:0]           w_diff;
  logic                  w_oob;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_idle   = !rst && (r_state == ST_IDLE);
  assign w_wr_req = awvalid && wvalid;
  assign w_wr_acc = w_idle && w_wr_req;
  assign w_rd_acc = w_idle && !w_wr_req && arvalid;
  assign w_accept = w_wr_acc || w_rd_acc;

  assign arready = w_idle && !w_wr_req;
  assign awready = w_wr_acc;
  assign wready  = w_wr_acc;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] w_lfsr;

  ysyx_23060240_lfsr8 u_lfsr (
    .clk    (clk),
    .i_load (rst),
    .i_seed (LFSR_SEED),
    .i_en   (w_accept),
    .o_q    (w_lfsr)
  );

  assign w_delay = 5'(LAT) + {2'b00, w_lfsr[2:0]};
`else
  assign w_delay = 5'(LAT);
`endif

  // With zero delay the response is produced straight from IDLE, so decode the live request
  assign w_cur_addr  = (r_state == ST_IDLE) ? (w_wr_req ? awaddr : araddr) : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;
  assign w_cur_wstrb = (r_state == ST_IDLE) ? wstrb : r_wstrb;

  // Borrow out of bit 32 flags addresses below the base
  assign w_diff = {1'b0, w_cur_addr} - {1'b0, BASE_ADDR};
  assign w_oob  = w_diff[32] || ((w_diff[31:0] >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_idx  = w_diff[DEPTH_LOG2+1:2];

  // Next-state and delay-counter logic
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_acc) begin
          w_ncnt   = w_delay;
          w_nstate = (w_delay == 5'd0) ? ST_WR_RESP : ST_WR_WAIT;
        end else if (w_rd_acc) begin
          w_ncnt   = w_delay;
          w_nstate = (w_delay == 5'd0) ? ST_RD_RESP : ST_RD_WAIT;
        end else begin
          w_nstate = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == 5'd0) begin
          w_nstate = ST_RD_RESP;
        end else begin
          w_ncnt = r_cnt - 5'd1;
        end
      end
      ST_RD_RESP: begin
        if (rready) begin
          w_nstate = ST_IDLE;
        end else begin
          w_nstate = ST_RD_RESP;
        end
      end
      ST_WR_WAIT: begin
        if (r_cnt == 5'd0) begin
          w_nstate = ST_WR_RESP;
        end else begin
          w_ncnt = r_cnt - 5'd1;
        end
      end
      ST_WR_RESP: begin
        if (bready) begin
          w_nstate = ST_IDLE;
        end else begin
          w_nstate = ST_WR_RESP;
        end
      end
      default: begin
        w_nstate = ST_IDLE;
      end
    endcase
  end

  assign w_rd_done = !rst && (w_nstate == ST_RD_RESP) && (r_state != ST_RD_RESP);
  assign w_wr_done = !rst && (w_nstate == ST_WR_RESP) && (r_state != ST_WR_RESP);

  // Control state, latched request and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 5'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_rdata  <= 32'd0;
      r_rresp  <= RESP_OKAY;
      r_bresp  <= RESP_OKAY;
      r_rvalid <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_rvalid <= (w_nstate == ST_RD_RESP);
      r_bvalid <= (w_nstate == ST_WR_RESP);
      if (w_accept) begin
        r_addr <= w_cur_addr;
      end
      if (w_wr_acc) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_rd_done) begin
        r_rresp <= w_oob ? RESP_SLVERR : RESP_OKAY;
        r_rdata <= w_oob ? 32'd0 : r_mem[w_idx];
      end
      if (w_wr_done) begin
        r_bresp <= w_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // RAM array is never reset; a write commits as its response is raised
  always_ff @(posedge clk) begin
    if (w_wr_done && !w_oob) begin
      r_mem[w_idx] <= merge_bytes(r_mem[w_idx], w_cur_wdata, w_cur_wstrb);
    end
  end

  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign rvalid = r_rvalid;
  assign bresp  = r_bresp;
  assign bvalid = r_bvalid;

endmodule

// File: tb/tb_ysyx_23060240_axil_sram.sv
// Directed self-checking bench: instance 0 runs with LAT=1, instance 1 with LAT=4.
module tb_ysyx_23060240_axil_sram;

`ifdef SRAM_RAND_DELAY_EN
  localparam int JIT = 7;
`else
  localparam int JIT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v;
  logic [1:0][31:0] araddr_v, awaddr_v, wdata_v, rdata_v;
  logic [1:0]       arvalid_v, arready_v, rvalid_v, rready_v;
  logic [1:0]       awvalid_v, awready_v, wvalid_v, wready_v, bvalid_v, bready_v;
  logic [1:0][1:0]  rresp_v, bresp_v;
  logic [1:0][3:0]  wstrb_v;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060240_axil_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(16), .LAT(1)) u_dut (
    .clk(clk), .rst(rst_v[0]),
    .araddr(araddr_v[0]), .arvalid(arvalid_v[0]), .arready(arready_v[0]),
    .rdata(rdata_v[0]), .rresp(rresp_v[0]), .rvalid(rvalid_v[0]), .rready(rready_v[0]),
    .awaddr(awaddr_v[0]), .awvalid(awvalid_v[0]), .awready(awready_v[0]),
    .wdata(wdata_v[0]), .wstrb(wstrb_v[0]), .wvalid(wvalid_v[0]), .wready(wready_v[0]),
    .bresp(bresp_v[0]), .bvalid(bvalid_v[0]), .bready(bready_v[0])
  );

  ysyx_23060240_axil_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(16), .LAT(4)) u_dut4 (
    .clk(clk), .rst(rst_v[1]),
    .araddr(araddr_v[1]), .arvalid(arvalid_v[1]), .arready(arready_v[1]),
    .rdata(rdata_v[1]), .rresp(rresp_v[1]), .rvalid(rvalid_v[1]), .rready(rready_v[1]),
    .awaddr(awaddr_v[1]), .awvalid(awvalid_v[1]), .awready(awready_v[1]),
    .wdata(wdata_v[1]), .wstrb(wstrb_v[1]), .wvalid(wvalid_v[1]), .wready(wready_v[1]),
    .bresp(bresp_v[1]), .bvalid(bvalid_v[1]), .bready(bready_v[1])
  );

  // Called just after a posedge; returns lat = cycles from handshake edge to bvalid, -1 on timeout
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                          input logic [3:0] s, output logic [1:0] resp, output int lat);
    int n;
    awaddr_v[d] = a; wdata_v[d] = dat; wstrb_v[d] = s;
    awvalid_v[d] = 1'b1; wvalid_v[d] = 1'b1; bready_v[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!awready_v[d] && n < 64) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid_v[d] = 1'b0; wvalid_v[d] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bvalid_v[d] && lat < 64) begin @(negedge clk); lat++; end
    if (n >= 64 || lat >= 64) lat = -1;
    resp = bresp_v[d];
    bready_v[d] = 1'b1;
    @(posedge clk); #1;
    bready_v[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] dat,
                         output logic [1:0] resp, output int lat);
    int n;
    araddr_v[d] = a; arvalid_v[d] = 1'b1; rready_v[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready_v[d] && n < 64) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid_v[d] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rvalid_v[d] && lat < 64) begin @(negedge clk); lat++; end
    if (n >= 64 || lat >= 64) lat = -1;
    dat = rdata_v[d]; resp = rresp_v[d];
    rready_v[d] = 1'b1;
    @(posedge clk); #1;
    rready_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_v = 2'b11;
    araddr_v = '0; awaddr_v = '0; wdata_v = '0; wstrb_v = '0;
    arvalid_v = 2'b11; awvalid_v = 2'b11; wvalid_v = 2'b11;
    rready_v = '0; bready_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({arready_v[0], awready_v[0], wready_v[0], rvalid_v[0], bvalid_v[0]} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl got ar/aw/w/r/b=%b need 00000",
               {arready_v[0], awready_v[0], wready_v[0], rvalid_v[0], bvalid_v[0]});
    end
    n_checks++;
    if ({rdata_v[0], rresp_v[0], bresp_v[0]} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b need 0", rdata_v[0], rresp_v[0], bresp_v[0]);
    end
    @(posedge clk); #1;
    arvalid_v = '0; awvalid_v = '0; wvalid_v = '0;
    rst_v = 2'b00;
    @(negedge clk);
    n_checks++;
    if (arready_v[0] !== 1'b1 || awready_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready got arready=%b awready=%b need 1 0", arready_v[0], awready_v[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_write();
    logic [1:0] resp; logic [31:0] dat; int lat;
    do_write(0, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, resp, lat);
    n_checks++;
    if (lat < 2 || lat > 2 + JIT || resp !== 2'b00) begin
      n_fail++; $display("FAIL full_write got lat=%0d bresp=%b need lat 2 bresp 00", lat, resp);
    end
    do_read(0, 32'h8000_0000, dat, resp, lat);
    n_checks++;
    if (lat < 2 || lat > 2 + JIT || resp !== 2'b00 || dat !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL full_read got lat=%0d rresp=%b rdata=%h need 2 00 deadbeef", lat, resp, dat);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] dat; int lat;
    do_write(0, 32'h8000_0000, 32'h0000_AB00, 4'b0010, resp, lat);
    n_checks++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL strb_bresp got %b need 00", resp); end
    do_read(0, 32'h8000_0000, dat, resp, lat);
    n_checks++;
    if (dat !== 32'hDEAD_ABEF || resp !== 2'b00) begin
      n_fail++; $display("FAIL strb_read got rdata=%h rresp=%b need deadabef 00", dat, resp);
    end
    do_read(0, 32'h8000_0003, dat, resp, lat);
    n_checks++;
    if (dat !== 32'hDEAD_ABEF || resp !== 2'b00) begin
      n_fail++; $display("FAIL unaligned_read got rdata=%h rresp=%b need deadabef 00", dat, resp);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] bad [3];
    logic [1:0] resp; logic [31:0] dat; int lat;
    bad[0] = 32'h7FFF_FFFC; bad[1] = 32'h8004_0000; bad[2] = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      do_read(0, bad[i], dat, resp, lat);
      n_checks++;
      if (resp !== 2'b10 || dat !== 32'd0 || lat < 0) begin
        n_fail++; $display("FAIL oob_read[%0d] got rresp=%b rdata=%h lat=%0d need 10 0", i, resp, dat, lat);
      end
    end
    do_write(0, 32'h8004_0000, 32'hFFFF_FFFF, 4'hF, resp, lat);
    n_checks++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL oob_write got bresp=%b need 10", resp); end
    do_read(0, 32'h8000_0000, dat, resp, lat);
    n_checks++;
    if (dat !== 32'hDEAD_ABEF) begin n_fail++; $display("FAIL oob_no_alias got %h need deadabef", dat); end
    do_write(0, 32'h8003_FFFC, 32'h1234_5678, 4'hF, resp, lat);
    n_checks++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL last_word_write got bresp=%b need 00", resp); end
    do_read(0, 32'h8003_FFFC, dat, resp, lat);
    n_checks++;
    if (dat !== 32'h1234_5678 || resp !== 2'b00) begin
      n_fail++; $display("FAIL last_word_read got rdata=%h rresp=%b need 12345678 00", dat, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; int lat; int n;
    do_write(0, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, resp, lat);
    araddr_v[0] = 32'h8000_0004; arvalid_v[0] = 1'b1; rready_v[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready_v[0] && n < 64) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid_v[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid_v[0] && n < 64) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid_v[0] !== 1'b1 || rdata_v[0] !== 32'hCAFE_F00D) begin
        n_fail++; $display("FAIL hold[%0d] got rvalid=%b rdata=%h need 1 cafef00d", i, rvalid_v[0], rdata_v[0]);
      end
    end
    rready_v[0] = 1'b1;
    @(posedge clk); #1;
    rready_v[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid_v[0] !== 1'b0) begin n_fail++; $display("FAIL rvalid_drop got %b need 0", rvalid_v[0]); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (arready_v[0] !== 1'b1) begin n_fail++; $display("FAIL rearm_arready got %b need 1", arready_v[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_priority();
    int n;
    araddr_v[0] = 32'h8000_0008; awaddr_v[0] = 32'h8000_0008;
    wdata_v[0] = 32'h1357_2468; wstrb_v[0] = 4'hF;
    arvalid_v[0] = 1'b1; awvalid_v[0] = 1'b1; wvalid_v[0] = 1'b1;
    bready_v[0] = 1'b1; rready_v[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({arready_v[0], awready_v[0], wready_v[0]} !== 3'b011) begin
      n_fail++; $display("FAIL prio_accept got ar/aw/w=%b need 011", {arready_v[0], awready_v[0], wready_v[0]});
    end
    @(posedge clk); #1;
    awvalid_v[0] = 1'b0; wvalid_v[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid_v[0] && n < 64) begin @(negedge clk); n++; end
    n_checks++;
    if (bvalid_v[0] !== 1'b1 || arready_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL prio_bvalid got bvalid=%b arready=%b need 1 0", bvalid_v[0], arready_v[0]);
    end
    n = 0;
    while (!arready_v[0] && n < 64) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid_v[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid_v[0] && n < 64) begin @(negedge clk); n++; end
    n_checks++;
    if (rvalid_v[0] !== 1'b1 || rdata_v[0] !== 32'h1357_2468 || rresp_v[0] !== 2'b00) begin
      n_fail++; $display("FAIL prio_read got rvalid=%b rdata=%h rresp=%b need 1 13572468 00",
                         rvalid_v[0], rdata_v[0], rresp_v[0]);
    end
    @(posedge clk); #1;
    bready_v[0] = 1'b0; rready_v[0] = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [1:0] resp; logic [31:0] dat; int lat; int n; logic seen;
    do_write(1, 32'h8000_0010, 32'hA5A5_0F0F, 4'hF, resp, lat);
    n_checks++;
    if (lat < 5 || lat > 5 + JIT || resp !== 2'b00) begin
      n_fail++; $display("FAIL lat4_write got lat=%0d bresp=%b need 5 00", lat, resp);
    end
    araddr_v[1] = 32'h8000_0010; arvalid_v[1] = 1'b1; rready_v[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready_v[1] && n < 64) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid_v[1] = 1'b0;
    @(posedge clk); #1;
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rvalid_v[1] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL dropped_read got rvalid seen=%b need 0", seen); end
    @(posedge clk); #1;
    rready_v[1] = 1'b0;
    do_read(1, 32'h8000_0010, dat, resp, lat);
    n_checks++;
    if (lat < 5 || lat > 5 + JIT || dat !== 32'hA5A5_0F0F || resp !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_read got lat=%0d rdata=%h rresp=%b need 5 a5a50f0f 00", lat, dat, resp);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_write_priority();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
